// File: rtl/rect_pkg.sv
// Shared types and constants for the rectangle DMA stream receiver.
`ifndef COORD_WIDTH
`define COORD_WIDTH 10
`endif

package rect_pkg;

  localparam int COORD_W           = `COORD_WIDTH;
  localparam int RECT_COUNT        = 64;
  localparam int RECT_PACKET_WORDS = 6;

  localparam logic [2:0] FLD_MARK  = 3'd0;
  localparam logic [2:0] FLD_X     = 3'd1;
  localparam logic [2:0] FLD_Y     = 3'd2;
  localparam logic [2:0] FLD_W     = 3'd3;
  localparam logic [2:0] FLD_H     = 3'd4;
  localparam logic [2:0] FLD_COLOR = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_PENDING = 2'd2
  } rx_state_e;

  // valid is the last field so it sits at bit 0 of the packed word.
  typedef struct packed {
    logic [COORD_W-1:0] x0;
    logic [COORD_W-1:0] y0;
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y1;
    logic [15:0]        color;
    logic               valid;
  } rect_t;

endpackage

// File: rtl/rect_stream_receiver_if.sv
// DMA write stream, frame control and rasterizer read port of the receiver.
interface rect_stream_receiver_if #(
  parameter int COORD_WIDTH = rect_pkg::COORD_W,
  parameter int RECT_COUNT  = rect_pkg::RECT_COUNT
);

  localparam int IDX_W = $clog2(RECT_COUNT);

  // No backpressure: after copy_start the receiver takes one din word on
  // every clock edge until the frame is complete; there is no valid/ready.
  logic                   copy_start;
  logic [15:0]            din;
  logic                   frame_swap;
  logic [IDX_W-1:0]       rd_index;
  logic [COORD_WIDTH-1:0] rd_x0;
  logic [COORD_WIDTH-1:0] rd_y0;
  logic [COORD_WIDTH-1:0] rd_x1;
  logic [COORD_WIDTH-1:0] rd_y1;
  logic [15:0]            rd_color;
  logic                   rd_valid;
  logic                   busy;
  logic                   frame_pending;
  logic                   sync_err;
  rect_pkg::rx_state_e    state_dbg;

  modport master (
    output copy_start, din, frame_swap, rd_index,
    input  rd_x0, rd_y0, rd_x1, rd_y1, rd_color, rd_valid,
    input  busy, frame_pending, sync_err, state_dbg
  );

  modport slave (
    input  copy_start, din, frame_swap, rd_index,
    output rd_x0, rd_y0, rd_x1, rd_y1, rd_color, rd_valid,
    output busy, frame_pending, sync_err, state_dbg
  );

endinterface

// File: rtl/rect_bank.sv
// One bank of the rectangle table: sync write, registered read.
module rect_bank #(
  parameter int RECT_COUNT = rect_pkg::RECT_COUNT,
  localparam int IDX_W     = $clog2(RECT_COUNT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_index,
  input  rect_pkg::rect_t   wr_data,
  input  logic [IDX_W-1:0]  rd_index,
  output rect_pkg::rect_t   rd_data
);
  import rect_pkg::*;

  localparam int PAYLOAD_W = $bits(rect_t) - 1;

  // Payload lives in plain memory; only the valid bits need clearing on reset.
  logic [PAYLOAD_W-1:0] mem [RECT_COUNT];
  logic [RECT_COUNT-1:0] valid_q;
  logic [PAYLOAD_W-1:0] rd_payload_q;
  logic                 rd_valid_q;

  always_ff @(posedge clk) begin
    if (we) mem[wr_index] <= wr_data[PAYLOAD_W:1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q      <= '0;
      rd_payload_q <= '0;
      rd_valid_q   <= 1'b0;
    end else begin
      if (we) valid_q[wr_index] <= wr_data.valid;
      rd_payload_q <= mem[rd_index];
      rd_valid_q   <= valid_q[rd_index];
    end
  end

  assign rd_data = rect_t'({rd_payload_q, rd_valid_q});

endmodule

// File: rtl/rect_stream_receiver.sv
// Deserialises rectangle packets into the back bank of a double-buffered table.
module rect_stream_receiver #(
  parameter int COORD_WIDTH  = rect_pkg::COORD_W,
  parameter int RECT_COUNT   = rect_pkg::RECT_COUNT,
  parameter int PACKET_WORDS = rect_pkg::RECT_PACKET_WORDS
) (
  input  logic clk,
  input  logic reset,
  rect_stream_receiver_if.slave bus
);
  import rect_pkg::*;

  localparam int IDX_W = $clog2(RECT_COUNT);
  localparam logic [2:0]       LAST_FIELD = 3'(PACKET_WORDS - 1);
  localparam logic [IDX_W-1:0] LAST_RECT  = IDX_W'(RECT_COUNT - 1);

  rx_state_e              state;
  logic [2:0]             word_cnt;
  logic [IDX_W-1:0]       rect_cnt;
  logic [COORD_WIDTH-1:0] x_q, y_q, w_q, h_q;
  logic                   front_sel;
  logic                   busy_q, pending_q, sync_err_q;

  logic                   wr_en;
  logic [COORD_WIDTH:0]   sum_x, sum_y;
  rect_t                  wr_rect;
  rect_t                  rd_bank0, rd_bank1, rd_front;

  // Corner conversion happens on the colour word, using the latched fields.
  always_comb begin
    sum_x         = {1'b0, x_q} + {1'b0, w_q};
    sum_y         = {1'b0, y_q} + {1'b0, h_q};
    wr_rect       = '0;
    wr_rect.x0    = x_q;
    wr_rect.y0    = y_q;
    wr_rect.x1    = sum_x[COORD_WIDTH] ? '1 : sum_x[COORD_WIDTH-1:0];
    wr_rect.y1    = sum_y[COORD_WIDTH] ? '1 : sum_y[COORD_WIDTH-1:0];
    wr_rect.color = bus.din;
    wr_rect.valid = (w_q != '0) && (h_q != '0);
  end

  assign wr_en = (state == ST_LOAD) && (word_cnt == LAST_FIELD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      word_cnt   <= '0;
      rect_cnt   <= '0;
      x_q        <= '0;
      y_q        <= '0;
      w_q        <= '0;
      h_q        <= '0;
      front_sel  <= 1'b0;
      busy_q     <= 1'b0;
      pending_q  <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          word_cnt <= '0;
          rect_cnt <= '0;
          if (bus.copy_start) begin
            state  <= ST_LOAD;
            busy_q <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (bus.copy_start) sync_err_q <= 1'b1;
          case (word_cnt)
            FLD_MARK: if (bus.din != 16'h0) sync_err_q <= 1'b1;
            FLD_X:    x_q <= bus.din[COORD_WIDTH-1:0];
            FLD_Y:    y_q <= bus.din[COORD_WIDTH-1:0];
            FLD_W:    w_q <= bus.din[COORD_WIDTH-1:0];
            FLD_H:    h_q <= bus.din[COORD_WIDTH-1:0];
            default:  ;
          endcase
          if (word_cnt == LAST_FIELD) begin
            word_cnt <= '0;
            rect_cnt <= rect_cnt + 1'b1;
            if (rect_cnt == LAST_RECT) begin
              state     <= ST_PENDING;
              busy_q    <= 1'b0;
              pending_q <= 1'b1;
            end
          end else begin
            word_cnt <= word_cnt + 3'd1;
          end
        end
        ST_PENDING: begin
          if (bus.copy_start) sync_err_q <= 1'b1;
          if (bus.frame_swap) begin
            front_sel <= ~front_sel;
            pending_q <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The back bank is whichever one front_sel does not point at.
  rect_bank #(.RECT_COUNT(RECT_COUNT)) u_bank0 (
    .clk      (clk),
    .reset    (reset),
    .we       (wr_en && front_sel),
    .wr_index (rect_cnt),
    .wr_data  (wr_rect),
    .rd_index (bus.rd_index),
    .rd_data  (rd_bank0)
  );

  rect_bank #(.RECT_COUNT(RECT_COUNT)) u_bank1 (
    .clk      (clk),
    .reset    (reset),
    .we       (wr_en && !front_sel),
    .wr_index (rect_cnt),
    .wr_data  (wr_rect),
    .rd_index (bus.rd_index),
    .rd_data  (rd_bank1)
  );

  assign rd_front          = front_sel ? rd_bank1 : rd_bank0;
  assign bus.rd_x0         = rd_front.x0;
  assign bus.rd_y0         = rd_front.y0;
  assign bus.rd_x1         = rd_front.x1;
  assign bus.rd_y1         = rd_front.y1;
  assign bus.rd_color      = rd_front.color;
  assign bus.rd_valid      = rd_front.valid;
  assign bus.busy          = busy_q;
  assign bus.frame_pending = pending_q;
  assign bus.sync_err      = sync_err_q;
  assign bus.state_dbg     = state;

endmodule
